// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer and the master controller.
// Contents:
//   seq_state_t      - sequencer state encoding (IDLE=0, READ=1, DRAIN=2, SWAP=3)
//   PIPE_LAT_DEFAULT - default read-to-pooling-output latency of the datapath
//   ABUFFER_DEFAULT  - default neuron buffer address width
//   CW_DEFAULT       - default width of the completed-layer counter
package neuron_layer_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SWAP  = 2'd3
    } seq_state_t;

    localparam int PIPE_LAT_DEFAULT = 4;
    localparam int ABUFFER_DEFAULT  = 11;
    localparam int CW_DEFAULT       = 8;

endpackage

// File: rtl/neuron_layer_sequencer_valid_delay_line.sv
// valid_delay_line: DEPTH-stage shift register that tracks which issued read
// vectors are still travelling through the convolution/pooling pipeline.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset, clears every stage
//   enable    - advance the line by one stage (low = freeze in place)
//   valid_in  - a read was issued this cycle
//   valid_out - the vector issued DEPTH advances ago is at the pooling output
//   any_valid - at least one tracked vector is still in flight
module valid_delay_line
    import neuron_layer_sequencer_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic valid_in,
    output logic valid_out,
    output logic any_valid
);

    logic [DEPTH-1:0] stage_reg;
    logic [DEPTH-1:0] stage_next;

    // Stage 0 takes the new issue flag, every other stage takes its predecessor.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_next[gi] = valid_in;
            end else begin : g_tail
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else if (enable) begin
            stage_reg <= stage_next;
        end
    end

    assign valid_out = stage_reg[DEPTH-1];
    assign any_valid = |stage_reg;

endmodule

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: runs one layer pass through the datapath.
// Streams read addresses into the active neuron buffer, tracks each vector
// through the pipeline, writes results (optionally pair-decimated for pooling)
// into the opposite buffer, then swaps the ping-pong buffers.
// Ports:
//   CLK, RSTn          - clock (rising edge), asynchronous active-low reset
//   start              - one-cycle layer request, honoured only when idle
//   rdBase, wrBase     - first read / write address, latched on start
//   rdCount            - number of vectors to read, latched on start
//   poolCfg            - pooling enable, latched on start
//   stall              - freezes read issue, in-flight tracking and writes
//   nReadAddress       - read buffer address
//   nWriteAddress      - write buffer address (holds last value between writes)
//   nWWrite            - write strobe into the write buffer
//   readBufferSelect   - which buffer is read; the other is written
//   doPooling          - latched pooling enable for the current layer
//   busy, done         - activity flag and one-cycle completion pulse
//   layerCount         - number of completed buffer swaps (wraps)
module neuron_layer_sequencer
    import neuron_layer_sequencer_pkg::*;
#(
    parameter int ABuffer  = ABUFFER_DEFAULT,
    parameter int PIPE_LAT = PIPE_LAT_DEFAULT,
    parameter int CW       = CW_DEFAULT
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               start,
    input  logic [ABuffer-1:0] rdBase,
    input  logic [ABuffer-1:0] wrBase,
    input  logic [ABuffer-1:0] rdCount,
    input  logic               poolCfg,
    input  logic               stall,
    output logic [ABuffer-1:0] nReadAddress,
    output logic [ABuffer-1:0] nWriteAddress,
    output logic               nWWrite,
    output logic               readBufferSelect,
    output logic               doPooling,
    output logic               busy,
    output logic               done,
    output logic [CW-1:0]      layerCount
);

    seq_state_t         state_reg;
    logic [ABuffer-1:0] rd_addr_reg;
    logic [ABuffer-1:0] rd_left_reg;
    logic [ABuffer-1:0] wr_next_reg;
    logic [ABuffer-1:0] wr_last_reg;
    logic               pair_reg;
    logic               pool_reg;
    logic               sel_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [CW-1:0]      layer_cnt_reg;

    logic issue;
    logic pipe_out;
    logic pipe_any;
    logic pipe_take;
    logic write_fire;

    assign issue     = (state_reg == ST_READ) && !stall;
    // A result leaves the pipe only on a non-stalled cycle; with pooling only
    // the second result of each pair produces a write.
    assign pipe_take  = pipe_out && !stall;
    assign write_fire = pipe_take && (!pool_reg || pair_reg);

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay_line (
        .clk       (CLK),
        .rst_n     (RSTn),
        .enable    (!stall),
        .valid_in  (issue),
        .valid_out (pipe_out),
        .any_valid (pipe_any)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg     <= ST_IDLE;
            rd_addr_reg   <= '0;
            rd_left_reg   <= '0;
            wr_next_reg   <= '0;
            wr_last_reg   <= '0;
            pair_reg      <= 1'b0;
            pool_reg      <= 1'b0;
            sel_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            layer_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;

            if (pipe_take && pool_reg) begin
                pair_reg <= ~pair_reg;
            end
            if (write_fire) begin
                wr_last_reg <= wr_next_reg;
                wr_next_reg <= wr_next_reg + ABuffer'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (rdCount != '0) begin
                            state_reg   <= ST_READ;
                            busy_reg    <= 1'b1;
                            rd_addr_reg <= rdBase;
                            rd_left_reg <= rdCount;
                            wr_next_reg <= wrBase;
                            pair_reg    <= 1'b0;
                            pool_reg    <= poolCfg;
                        end else begin
                            // Empty layer: acknowledge without touching the buffers.
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (!stall) begin
                        // The final address stays on the bus rather than running one past.
                        if (rd_left_reg == ABuffer'(1)) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            rd_left_reg <= rd_left_reg - ABuffer'(1);
                            rd_addr_reg <= rd_addr_reg + ABuffer'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!pipe_any) begin
                        state_reg <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    sel_reg       <= ~sel_reg;
                    layer_cnt_reg <= layer_cnt_reg + CW'(1);
                    done_reg      <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign nReadAddress     = rd_addr_reg;
    assign nWriteAddress    = write_fire ? wr_next_reg : wr_last_reg;
    assign nWWrite          = write_fire;
    assign readBufferSelect = sel_reg;
    assign doPooling        = pool_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign layerCount       = layer_cnt_reg;

endmodule
